ps2_direction_decoder: RTL

PS2_DIRECTION_DECODER -- requirements
Module: ps2_direction_decoder

---
 rtl/game2048_pkg.sv | 52 +++++
 rtl/ps2_rx.sv | 117 +++++++++++
 rtl/ps2_direction_decoder.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/game2048_pkg.sv
// Shared PS/2 scan codes, direction bit positions and FSM encodings.
// Latency: none (constants, types and a pure function).
// Backpressure: not applicable.
package game2048_pkg;

    // Set-2 scan codes used by the game
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_S     = 8'h1B;

    // One-hot direction bit positions, same order as KEY[3:0]
    localparam int DIR_UP    = 3;
    localparam int DIR_DOWN  = 2;
    localparam int DIR_LEFT  = 1;
    localparam int DIR_RIGHT = 0;

    // Held-key mask: bits 3..0 mirror the direction bits, bit 4 is the S key
    localparam int HELD_S    = 4;

    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_DATA   = 2'd1,
        RX_PARITY = 2'd2,
        RX_STOP   = 2'd3
    } rx_state_t;

    typedef enum logic [1:0] {
        D_IDLE    = 2'd0,
        D_EXT     = 2'd1,
        D_BRK     = 2'd2,
        D_EXT_BRK = 2'd3
    } dec_state_t;

    // Arrow scan code to one-hot direction; zero for any other code
    function automatic logic [3:0] arrow_onehot(input logic [7:0] code);
        logic [3:0] oh;
        oh = 4'b0000;
        case (code)
            SC_UP:    oh[DIR_UP]    = 1'b1;
            SC_DOWN:  oh[DIR_DOWN]  = 1'b1;
            SC_LEFT:  oh[DIR_LEFT]  = 1'b1;
            SC_RIGHT: oh[DIR_RIGHT] = 1'b1;
            default:  oh = 4'b0000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 serial frame receiver: synchronisers, 11-bit frame FSM, inactivity timeout.
// Latency: byte_valid/byte_err are combinational in the cycle the stop edge (or timeout) is seen.
// Backpressure: none; the keyboard cannot be stalled, so the consumer must take every byte.
module ps2_rx
    import game2048_pkg::*;
#(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] byte_dat,
    output logic       byte_valid,
    output logic       byte_err
);

    logic       clk_s1_q, clk_s2_q, clk_prev_q;
    logic       dat_s1_q, dat_s2_q;
    rx_state_t  state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       par_ok_q, par_ok_d;
    logic [15:0] to_cnt_q, to_cnt_d;
    logic       fall;
    logic       timeout;

    // Two-flop synchronisers plus a delayed copy of the synced clock for edge detection
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
        end else begin
            clk_s1_q   <= ps2_clk;
            clk_s2_q   <= clk_s1_q;
            clk_prev_q <= clk_s2_q;
            dat_s1_q   <= ps2_dat;
            dat_s2_q   <= dat_s1_q;
        end
    end

    assign fall    = clk_prev_q & ~clk_s2_q;
    // Fires after TIMEOUT_CYCLES consecutive edge-free cycles inside a frame
    assign timeout = (state_q != RX_IDLE) && !fall && (to_cnt_q == TIMEOUT_CYCLES - 16'd1);
    assign byte_dat = shift_q;

    // Frame FSM next state, shift register, parity and timeout bookkeeping
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_ok_d   = par_ok_q;
        byte_valid = 1'b0;
        byte_err   = 1'b0;
        if (state_q == RX_IDLE || fall) begin
            to_cnt_d = 16'd0;
        end else begin
            to_cnt_d = to_cnt_q + 16'd1;
        end

        if (timeout) begin
            state_d  = RX_IDLE;
            byte_err = 1'b1;
            to_cnt_d = 16'd0;
        end else if (fall) begin
            case (state_q)
                RX_IDLE: begin
                    // A high data line at a clock edge is noise, not a start bit
                    if (!dat_s2_q) begin
                        state_d   = RX_DATA;
                        bit_cnt_d = 3'd0;
                    end
                end
                RX_DATA: begin
                    shift_d   = {dat_s2_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = RX_PARITY;
                    end
                end
                RX_PARITY: begin
                    par_ok_d = ^{shift_q, dat_s2_q};
                    state_d  = RX_STOP;
                end
                default: begin
                    state_d = RX_IDLE;
                    if (par_ok_q && dat_s2_q) begin
                        byte_valid = 1'b1;
                    end else begin
                        byte_err = 1'b1;
                    end
                end
            endcase
        end
    end

    // Frame FSM state registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= RX_IDLE;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'd0;
            par_ok_q  <= 1'b0;
            to_cnt_q  <= 16'd0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_ok_q  <= par_ok_d;
            to_cnt_q  <= to_cnt_d;
        end
    end

endmodule

// File: rtl/ps2_direction_decoder.sv
// PS/2 keyboard to game move decoder: E0-prefixed arrows -> one-hot direction, S -> start pulse.
// Latency: outputs update on the clock edge after the stop-bit edge is detected.
// Backpressure: direction held with dir_valid until dir_ack; a newer arrow overwrites it.
// Optional: define PS2_TYPEMATIC_FILTER_EN to suppress auto-repeat makes of held keys.
module ps2_direction_decoder
    import game2048_pkg::*;
#(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    input  logic       dir_ack,
    output logic [3:0] direction,
    output logic       dir_valid,
    output logic       start_pulse,
    output logic       frame_err
);

    logic [7:0] byte_dat;
    logic       byte_valid;
    logic       byte_err;

    dec_state_t dec_state_q, dec_state_d;
    logic [3:0] direction_q, direction_d;
    logic       dir_valid_q, dir_valid_d;
    logic       start_pulse_q, start_pulse_d;
    logic       frame_err_q, frame_err_d;
    logic [3:0] arrow_oh;
    logic       make_arrow, make_s;
    logic       arrow_fire, start_fire;
`ifdef PS2_TYPEMATIC_FILTER_EN
    logic [4:0] held_q, held_d;
`endif

    ps2_rx #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .clock      (clock),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_dat    (ps2_dat),
        .byte_dat   (byte_dat),
        .byte_valid (byte_valid),
        .byte_err   (byte_err)
    );

    // Decode FSM state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dec_state_q <= D_IDLE;
        end else begin
            dec_state_q <= dec_state_d;
        end
    end

    // Decode FSM next state: track E0 / F0 prefixes, a bad frame drops any prefix
    always_comb begin
        dec_state_d = dec_state_q;
        if (byte_err) begin
            dec_state_d = D_IDLE;
        end else if (byte_valid) begin
            case (dec_state_q)
                D_IDLE: begin
                    if (byte_dat == SC_EXT) begin
                        dec_state_d = D_EXT;
                    end else if (byte_dat == SC_BRK) begin
                        dec_state_d = D_BRK;
                    end
                end
                D_EXT: begin
                    dec_state_d = (byte_dat == SC_BRK) ? D_EXT_BRK : D_IDLE;
                end
                default: dec_state_d = D_IDLE;
            endcase
        end
    end

    // Decode FSM outputs: move/start generation and the pending-move handshake
    always_comb begin
        arrow_oh   = arrow_onehot(byte_dat);
        make_arrow = byte_valid && (dec_state_q == D_EXT) && (arrow_oh != 4'b0000);
        make_s     = byte_valid && (dec_state_q == D_IDLE) && (byte_dat == SC_S);
`ifdef PS2_TYPEMATIC_FILTER_EN
        arrow_fire = make_arrow && ((arrow_oh & held_q[3:0]) == 4'b0000);
        start_fire = make_s && !held_q[HELD_S];
        held_d     = held_q;
        if (arrow_fire) begin
            held_d[3:0] = held_q[3:0] | arrow_oh;
        end
        if (start_fire) begin
            held_d[HELD_S] = 1'b1;
        end
        // Break codes release the key so the next press is reported again
        if (byte_valid && (dec_state_q == D_EXT_BRK)) begin
            held_d[3:0] = held_q[3:0] & ~arrow_oh;
        end
        if (byte_valid && (dec_state_q == D_BRK) && (byte_dat == SC_S)) begin
            held_d[HELD_S] = 1'b0;
        end
`else
        arrow_fire = make_arrow;
        start_fire = make_s;
`endif
        direction_d   = arrow_fire ? arrow_oh : direction_q;
        // A new arrow wins over a simultaneous ack so the move is never lost
        dir_valid_d   = arrow_fire ? 1'b1 : (dir_ack ? 1'b0 : dir_valid_q);
        start_pulse_d = start_fire;
        frame_err_d   = byte_err;
    end

    // Output registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            direction_q   <= 4'b0000;
            dir_valid_q   <= 1'b0;
            start_pulse_q <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            direction_q   <= direction_d;
            dir_valid_q   <= dir_valid_d;
            start_pulse_q <= start_pulse_d;
            frame_err_q   <= frame_err_d;
        end
    end

`ifdef PS2_TYPEMATIC_FILTER_EN
    // Held-key mask register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            held_q <= 5'd0;
        end else begin
            held_q <= held_d;
        end
    end
`endif

    assign direction   = direction_q;
    assign dir_valid   = dir_valid_q;
    assign start_pulse = start_pulse_q;
    assign frame_err   = frame_err_q;

endmodule
